// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard / stall controller for a 5-stage in-order pipeline.
// Decides, every cycle, whether the PC advances, whether IF/ID is held,
// squashed or passed through, whether ID/EX receives a bubble, and whether
// the pipeline registers are written at all. It also sequences the drain
// of the pipeline after a HLT instruction and keeps a saturating count of
// the cycles in which the PC did not advance.
//
// All control outputs are Mealy (combinational from state + inputs), so a
// hazard detected in a cycle is acted on in that same cycle.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous active-high reset
//   id_rs        in   4  ID-stage source register 1
//   id_rt        in   4  ID-stage source register 2
//   id_rs_used   in   1  ID instruction reads id_rs
//   id_rt_used   in   1  ID instruction reads id_rt
//   ex_memread   in   1  EX-stage instruction is a load
//   ex_rd        in   4  EX-stage destination register
//   branch_taken in   1  branch/jump resolved taken in ID this cycle
//   halt_id      in   1  HLT instruction present in ID
//   imem_stall   in   1  instruction fetch not valid this cycle
//   dmem_stall   in   1  data memory busy, MEM access incomplete
//   pc_wen       out  1  PC register write enable
//   ifid_nop     out  1  IF/ID hold: replay stored PC/instr, emit NOP
//   ifid_flush   out  1  IF/ID squash: emit NOP, PC advances
//   idex_bubble  out  1  zero ID/EX control signals
//   pipe_wen     out  1  write enable for all pipeline registers
//   halted       out  1  pipeline drained after HLT
//   stall_cnt    out  8  saturating count of cycles with pc_wen=0
// -----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       ex_memread,
    input  logic [3:0] ex_rd,
    input  logic       branch_taken,
    input  logic       halt_id,
    input  logic       imem_stall,
    input  logic       dmem_stall,
    output logic       pc_wen,
    output logic       ifid_nop,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       pipe_wen,
    output logic       halted,
    output logic [7:0] stall_cnt
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // actually reads. r0 is hard-wired zero, so a load "to r0" never hazards.
    logic lu;
    logic lu_rs_hit;
    logic lu_rt_hit;

    always_comb begin
        lu_rs_hit = id_rs_used && (id_rs == ex_rd);
        lu_rt_hit = id_rt_used && (id_rt == ex_rd);
        lu        = ex_memread && (ex_rd != 4'd0) && (lu_rs_hit || lu_rt_hit);
    end

    // -------------------------------------------------------------------------
    // Next state and Mealy outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // Default: free-running pipeline, nothing to do.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pc_wen      = 1'b1;
        ifid_nop    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_wen    = 1'b1;
        halted      = 1'b0;

        unique case (state_q)
            ST_RUN, ST_LU_STALL: begin
                // In LU_STALL the load has already moved on to MEM, so the
                // comparison against EX is stale and must be ignored; this
                // is what limits a load to exactly one bubble.
                if (dmem_stall) begin
                    pc_wen   = 1'b0;
                    pipe_wen = 1'b0;
                    state_d  = ST_MEM_WAIT;
                end else if (lu && (state_q == ST_RUN)) begin
                    // Branch (if any) is ignored here; it re-resolves next
                    // cycle once the loaded value can be forwarded.
                    pc_wen      = 1'b0;
                    ifid_nop    = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_LU_STALL;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    state_d    = ST_RUN;
                end else if (halt_id) begin
                    // HLT proceeds down the pipe; nothing younger follows.
                    pc_wen      = 1'b0;
                    ifid_flush  = 1'b1;
                    drain_cnt_d = 2'd3;
                    state_d     = ST_DRAIN;
                end else if (imem_stall) begin
                    // Fetch bubble: hold the PC and feed a NOP into ID.
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_MEM_WAIT: begin
                // Whole pipe frozen until the data access completes; the
                // release cycle behaves as an event-free RUN cycle.
                if (dmem_stall) begin
                    pc_wen   = 1'b0;
                    pipe_wen = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                // Let the instructions ahead of HLT retire. Only cycles in
                // which the pipe actually moves count towards the drain.
                pc_wen     = 1'b0;
                ifid_flush = 1'b1;
                if (dmem_stall) begin
                    pipe_wen = 1'b0;
                end else begin
                    if (drain_cnt_q <= 2'd1) begin
                        drain_cnt_d = 2'd0;
                        state_d     = ST_HALT;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 2'd1;
                    end
                end
            end

            ST_HALT: begin
                // Terminal until reset; the pipe keeps clocking NOPs.
                pc_wen      = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // While in reset, flush the front end and clock NOPs through the
        // rest of the pipeline so no stale instruction survives reset.
        if (rst) begin
            pc_wen      = 1'b0;
            ifid_nop    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_wen    = 1'b1;
            halted      = 1'b0;
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_wen && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 2'd0;
            stall_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. A behavioural reference model tracks
// the pipeline situation as a handful of flags (memory busy, load bubble
// already inserted, draining with N moves left, halted) plus a plain stall
// tally, and derives the expected control outputs from the hazard rules.
// Directed scenarios add literal expectations on top of the model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, ex_memread;
    logic       branch_taken, halt_id, imem_stall, dmem_stall;
    logic       pc_wen, ifid_nop, ifid_flush, idex_bubble, pipe_wen, halted;
    logic [7:0] stall_cnt;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .halt_id      (halt_id),
        .imem_stall   (imem_stall),
        .dmem_stall   (dmem_stall),
        .pc_wen       (pc_wen),
        .ifid_nop     (ifid_nop),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_wen     (pipe_wen),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // {pc_wen, ifid_nop, ifid_flush, idex_bubble, pipe_wen, halted, stall_cnt}
    logic [13:0] dut_vec;
    assign dut_vec = {pc_wen, ifid_nop, ifid_flush, idex_bubble, pipe_wen, halted, stall_cnt};

    // ------------------------------------------------------------------ model
    bit m_mem_wait;
    bit m_lu_masked;
    bit m_draining;
    bit m_halted;
    int m_drain_left;
    int m_stalls;

    function automatic bit load_use();
        bit reads_rd;
        reads_rd = (id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd);
        return ex_memread && (ex_rd != 0) && reads_rd;
    endfunction

    function automatic logic [13:0] model_out();
        logic pc, nop, fl, bub, pw, hl;
        pc = 1; nop = 0; fl = 0; bub = 0; pw = 1; hl = 0;
        if (rst) begin
            pc = 0; fl = 1; bub = 1;
        end else if (m_halted) begin
            pc = 0; fl = 1; bub = 1; hl = 1;
        end else if (m_draining) begin
            pc = 0; fl = 1; pw = !dmem_stall;
        end else if (m_mem_wait) begin
            if (dmem_stall) begin pc = 0; pw = 0; end
        end else if (dmem_stall) begin
            pc = 0; pw = 0;
        end else if (load_use() && !m_lu_masked) begin
            pc = 0; nop = 1; bub = 1;
        end else if (branch_taken) begin
            fl = 1;
        end else if (halt_id || imem_stall) begin
            pc = 0; fl = 1;
        end
        return {pc, nop, fl, bub, pw, hl, m_stalls[7:0]};
    endfunction

    function automatic void model_advance();
        logic [13:0] e;
        bit hit;
        e = model_out();
        if (rst) begin
            m_mem_wait = 0; m_lu_masked = 0; m_draining = 0; m_halted = 0;
            m_drain_left = 0; m_stalls = 0;
            return;
        end
        if (!e[13] && m_stalls < 255) m_stalls++;
        if (m_halted) begin
        end else if (m_draining) begin
            if (!dmem_stall) begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    m_draining = 0;
                    m_halted   = 1;
                end
            end
        end else if (m_mem_wait) begin
            if (!dmem_stall) m_mem_wait = 0;
        end else begin
            hit = load_use() && !m_lu_masked;
            m_lu_masked = 0;
            if (dmem_stall) m_mem_wait = 1;
            else if (hit) m_lu_masked = 1;
            else if (branch_taken) begin end
            else if (halt_id) begin
                m_draining   = 1;
                m_drain_left = 3;
            end
        end
    endfunction

    // -------------------------------------------------------- stimulus tasks
    task automatic step();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        ex_memread = 0; ex_rd = 0; branch_taken = 0; halt_id = 0;
        imem_stall = 0; dmem_stall = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        step();
        rst = 0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [13:0] e;
        rst = 1;
        idle_inputs();
        halt_id = 1; dmem_stall = 1; ex_memread = 1; ex_rd = 2; id_rs = 2; id_rs_used = 1;
        step();
        @(negedge clk);
        e = model_out();
        n_cmp++;
        if (dut_vec !== e) begin
            n_fail++;
            $display("FAIL reset_vec: got %b want %b", dut_vec, e);
        end
        n_cmp++;
        if ({pc_wen, ifid_nop, ifid_flush, idex_bubble, pipe_wen, halted, stall_cnt} !== {6'b001110, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", dut_vec, {6'b001110, 8'd0});
        end
        step();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (pc_wen !== 1'b1 || pipe_wen !== 1'b1 || stall_cnt !== 8'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b want pc_wen=1 pipe_wen=1 halted=0 stall_cnt=0", dut_vec);
        end
        step();
        $display("txn reset: done");
    endtask

    task automatic test_load_use();
        logic [13:0] e;
        do_reset();
        ex_memread = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
        @(negedge clk);
        e = model_out();
        n_cmp++;
        if (dut_vec !== e) begin
            n_fail++;
            $display("FAIL lu_vec: got %b want %b", dut_vec, e);
        end
        n_cmp++;
        if (pc_wen !== 1'b0 || ifid_nop !== 1'b1 || idex_bubble !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got pc=%b nop=%b bub=%b want 0 1 1", pc_wen, ifid_nop, idex_bubble);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (pc_wen !== 1'b1 || ifid_nop !== 1'b0 || stall_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL lu_one_bubble: got pc=%b nop=%b cnt=%0d want 1 0 1", pc_wen, ifid_nop, stall_cnt);
        end
        step();
        $display("txn load_use: done");
    endtask

    task automatic test_reg0_unused();
        do_reset();
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_rs_used = 1; id_rt = 0; id_rt_used = 1;
        @(negedge clk);
        n_cmp++;
        if (pc_wen !== 1'b1 || ifid_nop !== 1'b0 || dut_vec !== model_out()) begin
            n_fail++;
            $display("FAIL reg0: got %b want pc_wen=1 nop=0 (%b)", dut_vec, model_out());
        end
        step();
        ex_memread = 1; ex_rd = 5; id_rt = 5; id_rt_used = 0; id_rs = 2; id_rs_used = 1;
        @(negedge clk);
        n_cmp++;
        if (pc_wen !== 1'b1 || ifid_nop !== 1'b0 || dut_vec !== model_out()) begin
            n_fail++;
            $display("FAIL unused_rt: got %b want pc_wen=1 nop=0 (%b)", dut_vec, model_out());
        end
        step();
        $display("txn reg0_unused: done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        ex_memread = 1; ex_rd = 7; id_rt = 7; id_rt_used = 1; branch_taken = 1;
        @(negedge clk);
        n_cmp++;
        if (ifid_nop !== 1'b1 || ifid_flush !== 1'b0 || pc_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL br_lu: got nop=%b flush=%b pc=%b want 1 0 0", ifid_nop, ifid_flush, pc_wen);
        end
        step();
        ex_memread = 0;
        @(negedge clk);
        n_cmp++;
        if (ifid_flush !== 1'b1 || pc_wen !== 1'b1 || dut_vec !== model_out()) begin
            n_fail++;
            $display("FAIL br_resolve: got %b want flush=1 pc=1 (%b)", dut_vec, model_out());
        end
        step();
        $display("txn simultaneous: done");
    endtask

    task automatic test_mem_stall();
        do_reset();
        dmem_stall = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pipe_wen !== 1'b0 || pc_wen !== 1'b0 || dut_vec !== model_out()) begin
                n_fail++;
                $display("FAIL mem_hold[%0d]: got %b want %b", c, dut_vec, model_out());
            end
            step();
        end
        dmem_stall = 0;
        @(negedge clk);
        n_cmp++;
        if (pipe_wen !== 1'b1 || pc_wen !== 1'b1 || stall_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL mem_release: got pw=%b pc=%b cnt=%0d want 1 1 4", pipe_wen, pc_wen, stall_cnt);
        end
        step();
        $display("txn mem_stall: done");
    endtask

    task automatic test_halt(input bit interpose);
        int  drain_cycles;
        bit  done;
        drain_cycles = 0;
        done = 0;
        do_reset();
        halt_id = 1;
        @(negedge clk);
        n_cmp++;
        if (pc_wen !== 1'b0 || ifid_flush !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter: got pc=%b flush=%b halted=%b want 0 1 0", pc_wen, ifid_flush, halted);
        end
        step();
        halt_id = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            dmem_stall = interpose && (c == 1);
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %b want %b", c, dut_vec, model_out());
            end
            if (halted === 1'b1) done = 1;
            else begin
                drain_cycles++;
                step();
            end
        end
        dmem_stall = 0;
        n_cmp++;
        if (!done || drain_cycles != (interpose ? 4 : 3)) begin
            n_fail++;
            $display("FAIL drain_len: got %0d cycles (halted=%b) want %0d", drain_cycles, done, interpose ? 4 : 3);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            {id_rs, id_rt, ex_rd} = 12'($urandom);
            {id_rs_used, id_rt_used, ex_memread, branch_taken, halt_id, imem_stall, dmem_stall} = 7'($urandom);
            @(negedge clk);
            n_cmp++;
            if (halted !== 1'b1 || dut_vec !== model_out()) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %b want %b", c, dut_vec, model_out());
            end
        end
        step();
        do_reset();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (halted !== 1'b0 || pc_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_exit: got halted=%b pc=%b want 0 1", halted, pc_wen);
        end
        step();
        $display("txn halt interpose=%0d: drained in %0d cycles", interpose, drain_cycles);
    endtask

    task automatic test_saturation();
        do_reset();
        imem_stall = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_fail++;
                $display("FAIL sat[%0d]: got %b want %b", c, dut_vec, model_out());
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_value: got %h want ff", stall_cnt);
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 8'd0 || pc_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clear: got cnt=%h pc=%b want 00 1", stall_cnt, pc_wen);
        end
        step();
        $display("txn saturation: done");
    endtask

    task automatic test_random();
        logic [13:0] e;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            dmem_stall   = ($urandom_range(0, 99) < 15);
            ex_memread   = ($urandom_range(0, 99) < 40);
            ex_rd        = 4'($urandom_range(0, 3));
            id_rs        = 4'($urandom_range(0, 3));
            id_rt        = 4'($urandom_range(0, 3));
            id_rs_used   = ($urandom_range(0, 99) < 70);
            id_rt_used   = ($urandom_range(0, 99) < 70);
            branch_taken = ($urandom_range(0, 99) < 15);
            halt_id      = ($urandom_range(0, 99) < 4);
            imem_stall   = ($urandom_range(0, 99) < 15);
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL rand[%0d]: got %b want %b", c, dut_vec, e);
            end else begin
                $display("txn rand %0d: rst=%b dm=%b lu=%b br=%b hlt=%b im=%b -> %b", c, rst, dmem_stall,
                         load_use(), branch_taken, halt_id, imem_stall, dut_vec);
            end
            step();
        end
        rst = 0;
        idle_inputs();
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_reg0_unused();
        test_simultaneous();
        test_mem_stall();
        test_halt(1'b0);
        test_halt(1'b1);
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
